// File: rtl/rst_sequencer_pkg.sv
// Shared types for the Skywave-A reset sequencer: FSM states, reset causes
// and a small sizing helper for the shared cycle counter.
package skywave_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT    = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR       = 2'd0,
        CAUSE_LOCK_LOSS = 2'd1,
        CAUSE_SW        = 2'd2
    } cause_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Reset-distribution bundle: software reset handshake plus the staged resets
// and status the sequencer reports to the rest of the SoC.
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    import skywave_rst_pkg::*;

    logic                  sw_reset_req_i;
    logic                  sw_reset_ack_o;
    logic [NUM_STAGES-1:0] rst_o;
    logic                  ready_o;
    cause_t                cause_o;

    modport master (
        input  sw_reset_req_i,
        output sw_reset_ack_o,
        output rst_o,
        output ready_o,
        output cause_o
    );

    modport slave (
        output sw_reset_req_i,
        input  sw_reset_ack_o,
        input  rst_o,
        input  ready_o,
        input  cause_o
    );

endinterface

// File: rtl/rst_sequencer_sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into a clock
// domain; clears to zero on the async active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: waits for a stable PLL lock, then releases the downstream
// reset stages one at a time and re-enters reset on lock loss or software request.
module rst_sequencer
    import skywave_rst_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_STABLE = 64,
    parameter int HOLD_MIN    = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            pll_locked_i,
    rst_sequencer_if.master bus
);

    localparam int CNT_MAX = max3(STAGE_DELAY, LOCK_STABLE, HOLD_MIN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_MIN - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [NUM_STAGES-1:0] ALL_ASSERTED  = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] FIRST_RELEASE = ALL_ASSERTED << 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic [NUM_STAGES-1:0] rst_shift;
    cause_t                cause_q, cause_d;
    logic                  ready_q;
    logic                  ack_q, ack_d;
    logic                  lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk_i),
        .rst_n (reset_i),
        .d     (pll_locked_i),
        .q     (lock_s)
    );

    // Stages release lowest index first, so shifting in zeros from the bottom
    // clears exactly the next stage.
    assign rst_shift = rst_q << 1;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            rst_q   <= ALL_ASSERTED;
            cause_q <= CAUSE_POR;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            cause_q <= cause_d;
            ready_q <= (state_d == RUN);
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        cause_d = cause_q;
        ack_d   = 1'b0;

        unique case (state_q)
            ASSERT: begin
                rst_d = ALL_ASSERTED;
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    cnt_d   = '0;
                    rst_d   = FIRST_RELEASE;
                    state_d = (FIRST_RELEASE == '0) ? RUN : RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RELEASE: begin
                if (!lock_s) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    rst_d   = ALL_ASSERTED;
                    cause_d = CAUSE_LOCK_LOSS;
                end else if (cnt_q == STAGE_LAST) begin
                    cnt_d = '0;
                    rst_d = rst_shift;
                    if (rst_shift == '0) begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RUN: begin
                // A request coinciding with lock loss is still consumed and acked,
                // but lock loss is the reported cause.
                ack_d = bus.sw_reset_req_i;
                if (!lock_s || bus.sw_reset_req_i) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    rst_d   = ALL_ASSERTED;
                    cause_d = lock_s ? CAUSE_SW : CAUSE_LOCK_LOSS;
                end
            end

            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
                rst_d   = ALL_ASSERTED;
            end
        endcase
    end

    assign bus.rst_o          = rst_q;
    assign bus.ready_o        = ready_q;
    assign bus.cause_o        = cause_q;
    assign bus.sw_reset_ack_o = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: a timeline model of lock/release
// behaviour checked every cycle, plus hand-computed directed expectations.
module tb_rst_sequencer;

    localparam int NS = 3;
    localparam int SD = 4;
    localparam int LS = 8;
    localparam int HM = 2;

    logic clk;
    logic reset_n;
    logic pll_locked;

    int checks;
    int failures;
    int edge_no;

    rst_sequencer_if #(.NUM_STAGES(NS)) sif ();

    rst_sequencer #(
        .NUM_STAGES  (NS),
        .STAGE_DELAY (SD),
        .LOCK_STABLE (LS),
        .HOLD_MIN    (HM)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_n),
        .pll_locked_i (pll_locked),
        .bus          (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_no <= 0;
        else          edge_no <= edge_no + 1;
    end

    // Timeline model: m_rel is the edge on which stage 0 released (-1 while
    // held); stages cleared follow from elapsed edges divided by SD.
    logic m_q1, m_q2;
    int   m_since, m_good, m_rel, m_edge, m_cause;
    logic m_ack;

    function automatic int stagesAt(input int e, input int rel);
        int k;
        k = 1 + (e - rel) / SD;
        return (k > NS) ? NS : k;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int   since, good, rel, cause;
        logic ack, running, lock;
        if (!reset_n) begin
            m_q1    <= 1'b0;
            m_q2    <= 1'b0;
            m_since <= 0;
            m_good  <= 0;
            m_rel   <= -1;
            m_edge  <= 0;
            m_cause <= 0;
            m_ack   <= 1'b0;
        end else begin
            lock  = m_q2;
            since = m_since;
            good  = m_good;
            rel   = m_rel;
            cause = m_cause;
            ack   = 1'b0;
            if (rel < 0) begin
                if (since >= HM) begin
                    good = lock ? good + 1 : 0;
                    if (good == LS) begin
                        rel  = m_edge + 1;
                        good = 0;
                    end
                end
                since = since + 1;
            end else begin
                running = (stagesAt(m_edge, rel) >= NS);
                ack     = running && sif.sw_reset_req_i;
                if (!lock || ack) begin
                    cause = !lock ? 1 : 2;
                    rel   = -1;
                    since = 0;
                    good  = 0;
                end
            end
            m_q1    <= pll_locked;
            m_q2    <= m_q1;
            m_since <= since;
            m_good  <= good;
            m_rel   <= rel;
            m_edge  <= m_edge + 1;
            m_cause <= cause;
            m_ack   <= ack;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, edge_no);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [NS-1:0] full;
        logic [NS-1:0] exp_rst;
        logic          exp_ready;
        int            k;
        full = '1;
        if (m_rel < 0) begin
            exp_rst   = full;
            exp_ready = 1'b0;
        end else begin
            k         = stagesAt(m_edge, m_rel);
            exp_rst   = full << k;
            exp_ready = (k >= NS);
        end
        checkOutput("model_rst",   32'(sif.rst_o),          32'(exp_rst));
        checkOutput("model_ready", 32'(sif.ready_o),        32'(exp_ready));
        checkOutput("model_ack",   32'(sif.sw_reset_ack_o), 32'(m_ack));
        checkOutput("model_cause", 32'(sif.cause_o),        32'(m_cause));
    end

    task automatic waitEdge(input int n);
        while (edge_no < n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic lock, input logic req);
        pll_locked         = lock;
        sif.sw_reset_req_i = req;
    endtask

    task automatic restartFromPor();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #12;

        // POR with lock held: hold edges 1-2, lock counted 3-10, stages at 10/14/18.
        checkOutput("por_reset_rst",   32'(sif.rst_o),   32'h7);
        checkOutput("por_reset_ready", 32'(sif.ready_o), 32'h0);
        checkOutput("por_reset_cause", 32'(sif.cause_o), 32'h0);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            waitEdge(n);
            checkOutput("por_rst", 32'(sif.rst_o),
                        (n < 10) ? 32'h7 : (n < 14) ? 32'h6 : (n < 18) ? 32'h4 : 32'h0);
            checkOutput("por_ready", 32'(sif.ready_o), (n >= 18) ? 32'h1 : 32'h0);
        end
        checkOutput("por_cause", 32'(sif.cause_o), 32'h0);

        // Lock glitch seen by the counter at edge 8 pushes the release to edge 16.
        restartFromPor();
        waitEdge(5);
        applyStimulus(1'b0, 1'b0);
        waitEdge(6);
        applyStimulus(1'b1, 1'b0);
        waitEdge(10);
        checkOutput("glitch_rst_e10", 32'(sif.rst_o), 32'h7);
        waitEdge(15);
        checkOutput("glitch_rst_e15", 32'(sif.rst_o), 32'h7);
        waitEdge(16);
        checkOutput("glitch_rst_e16", 32'(sif.rst_o), 32'h6);
        waitEdge(24);
        checkOutput("glitch_ready", 32'(sif.ready_o), 32'h1);
        checkOutput("glitch_rst_run", 32'(sif.rst_o), 32'h0);

        // Lock loss in RUN: input drops after edge 26, reset re-enters on edge 29.
        waitEdge(26);
        applyStimulus(1'b0, 1'b0);
        waitEdge(28);
        checkOutput("loss_rst_e28",   32'(sif.rst_o),   32'h0);
        checkOutput("loss_ready_e28", 32'(sif.ready_o), 32'h1);
        waitEdge(29);
        checkOutput("loss_rst_e29",   32'(sif.rst_o),   32'h7);
        checkOutput("loss_ready_e29", 32'(sif.ready_o), 32'h0);
        checkOutput("loss_cause",     32'(sif.cause_o), 32'h1);
        waitEdge(30);
        applyStimulus(1'b1, 1'b0);
        waitEdge(48);
        checkOutput("relock_ready", 32'(sif.ready_o), 32'h1);
        checkOutput("relock_cause", 32'(sif.cause_o), 32'h1);

        // Software reset in RUN, request held through the whole re-sequence.
        waitEdge(50);
        applyStimulus(1'b1, 1'b1);
        waitEdge(51);
        checkOutput("sw_ack_e51",   32'(sif.sw_reset_ack_o), 32'h1);
        checkOutput("sw_rst_e51",   32'(sif.rst_o),          32'h7);
        checkOutput("sw_cause_e51", 32'(sif.cause_o),        32'h2);
        waitEdge(52);
        checkOutput("sw_ack_e52", 32'(sif.sw_reset_ack_o), 32'h0);
        waitEdge(65);
        checkOutput("held_req_rst_e65", 32'(sif.rst_o),          32'h4);
        checkOutput("held_req_ack_e65", 32'(sif.sw_reset_ack_o), 32'h0);
        waitEdge(69);
        checkOutput("held_req_ready_e69", 32'(sif.ready_o),        32'h1);
        checkOutput("held_req_ack_e69",   32'(sif.sw_reset_ack_o), 32'h0);
        waitEdge(70);
        checkOutput("held_req_ack_e70", 32'(sif.sw_reset_ack_o), 32'h1);
        checkOutput("held_req_rst_e70", 32'(sif.rst_o),          32'h7);
        applyStimulus(1'b1, 1'b0);

        // Async reset mid-release, between clock edges.
        waitEdge(84);
        checkOutput("mid_release_rst", 32'(sif.rst_o), 32'h4);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst",   32'(sif.rst_o),          32'h7);
        checkOutput("async_ready", 32'(sif.ready_o),        32'h0);
        checkOutput("async_cause", 32'(sif.cause_o),        32'h0);
        checkOutput("async_ack",   32'(sif.sw_reset_ack_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        waitEdge(22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
